// File: rtl/booth_mult_unit_pkg.sv
// Shared definitions for the iterative multiply/divide units: FSM state
// encodings and the iteration-counter width helper.
package booth_mult_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mult_state_e;

  // Counter must hold the value WIDTH, hence one extra bit over clog2.
  function automatic int unsigned mult_cnt_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into acc, then
// arithmetic right shift of {acc, Q, q_1} by one bit.
module booth_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q_1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q_1_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc_i;
    case ({q_i[0], q_1_i})
      2'b01:   sum = acc_i + m_i;
      2'b10:   sum = acc_i - m_i;
      default: sum = acc_i;
    endcase
    // Sign of acc is replicated into the vacated MSB.
    {acc_o, q_o, q_1_o} = {sum[WIDTH], sum, q_i};
  end

endmodule

// File: rtl/booth_mult_unit.sv
// Iterative signed WIDTH x WIDTH radix-2 Booth multiplier with HI/LO
// result registers, started by a one-cycle request from the control unit.
module booth_mult_unit
  import booth_mult_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             mult_busy,
  output logic             mult_done
);

  localparam int unsigned CNT_W = mult_cnt_w(WIDTH);

  mult_state_e      state_q, state_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH:0]   acc_q, acc_d, acc_nxt;
  logic [WIDTH-1:0] q_q, q_d, q_nxt;
  logic             q1_q, q1_d, q1_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .q_1_i (q1_q),
    .m_i   (m_q),
    .acc_o (acc_nxt),
    .q_o   (q_nxt),
    .q_1_o (q1_nxt)
  );

  // Next-state, datapath and output computation.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mult_start) begin
          state_d = ST_RUN;
          m_d     = {in_a[WIDTH-1], in_a};
          acc_d   = '0;
          q_d     = in_b;
          q1_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        acc_d = acc_nxt;
        q_d   = q_nxt;
        q1_d  = q1_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        // Last iteration: capture product straight from the step outputs.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
          hi_d    = acc_nxt[WIDTH-1:0];
          lo_d    = q_nxt;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_hi    = hi_q;
  assign out_lo    = lo_q;
  assign mult_busy = busy_q;
  assign mult_done = done_q;

endmodule

// File: tb/tb_booth_mult_unit.sv
// Directed testbench for booth_mult_unit: products, timing, start handling
// and mid-operation reset.
module tb_booth_mult_unit;

  logic        clk;
  logic        reset;
  logic        mult_start;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  logic        mult_busy;
  logic        mult_done;

  int errors = 0;
  int checks = 0;

  booth_mult_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_hi     (out_hi),
    .out_lo     (out_lo),
    .mult_busy  (mult_busy),
    .mult_done  (mult_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and watches it to completion; operands are scrambled
  // right after the start edge. Called at posedge+1 with the unit idle.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output int busy_cyc, output int done_cyc,
                         output int done_at, output logic stable,
                         output logic timed_out);
    logic [31:0] hi0, lo0;
    in_a = a;
    in_b = b;
    mult_start = 1'b1;
    tick();
    mult_start = 1'b0;
    in_a = 32'hDEADBEEF;
    in_b = 32'h12345678;
    hi0 = out_hi;
    lo0 = out_lo;
    busy_cyc = 0;
    done_cyc = 0;
    done_at = 0;
    stable = 1'b1;
    while (mult_busy === 1'b1 && busy_cyc < 100) begin
      busy_cyc++;
      if (mult_done === 1'b1) begin
        done_cyc++;
        done_at = busy_cyc;
      end else if (out_hi !== hi0 || out_lo !== lo0) begin
        stable = 1'b0;
      end
      tick();
    end
    timed_out = (busy_cyc >= 100);
    hi = out_hi;
    lo = out_lo;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mult_start = 1'b0;
    in_a = '0;
    in_b = '0;
    repeat (3) tick();
    reset = 1'b0;
    checks++; if (out_hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=%h", out_hi, 32'h0); end
    checks++; if (out_lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=%h", out_lo, 32'h0); end
    checks++; if (mult_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", mult_busy); end
    checks++; if (mult_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", mult_done); end
    tick();
  endtask

  task automatic test_small();
    logic [31:0] hi, lo;
    int bc, dc, da;
    logic st, to;
    do_mult(32'd3, 32'd5, hi, lo, bc, dc, da, st, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL small_timeout busy never dropped"); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL small_hi got=%h exp=%h", hi, 32'h0); end
    checks++; if (lo !== 32'hF) begin errors++; $display("FAIL small_lo got=%h exp=%h", lo, 32'hF); end
    checks++; if (bc != 33) begin errors++; $display("FAIL small_busy_cycles got=%0d exp=33", bc); end
    checks++; if (dc != 1) begin errors++; $display("FAIL small_done_pulses got=%0d exp=1", dc); end
    checks++; if (da != 33) begin errors++; $display("FAIL small_done_position got=%0d exp=33", da); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL small_hilo_stable got=%b exp=1", st); end
  endtask

  task automatic test_signed();
    logic [31:0] hi, lo;
    int bc, dc, da;
    logic st, to;
    do_mult(32'hFFFFFFF9, 32'd6, hi, lo, bc, dc, da, st, to);
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL neg7x6_hi got=%h exp=%h", hi, 32'hFFFFFFFF); end
    checks++; if (lo !== 32'hFFFFFFD6) begin errors++; $display("FAIL neg7x6_lo got=%h exp=%h", lo, 32'hFFFFFFD6); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL neg7x6_hilo_stable got=%b exp=1", st); end
    tick();
    do_mult(32'h80000000, 32'h80000000, hi, lo, bc, dc, da, st, to);
    checks++; if (hi !== 32'h40000000) begin errors++; $display("FAIL minneg_hi got=%h exp=%h", hi, 32'h40000000); end
    checks++; if (lo !== 32'h00000000) begin errors++; $display("FAIL minneg_lo got=%h exp=%h", lo, 32'h0); end
    tick();
    do_mult(32'h7FFFFFFF, 32'hFFFFFFFF, hi, lo, bc, dc, da, st, to);
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL maxpos_hi got=%h exp=%h", hi, 32'hFFFFFFFF); end
    checks++; if (lo !== 32'h80000001) begin errors++; $display("FAIL maxpos_lo got=%h exp=%h", lo, 32'h80000001); end
    checks++; if (bc != 33) begin errors++; $display("FAIL maxpos_busy_cycles got=%0d exp=33", bc); end
    checks++; if (dc != 1 || da != 33) begin errors++; $display("FAIL maxpos_done pulses=%0d at=%0d exp 1 at 33", dc, da); end
    tick();
  endtask

  // Start held high through the whole operation; operands change after E0.
  task automatic test_start_held();
    int n, dones;
    logic moved;
    in_a = 32'd3;
    in_b = 32'd5;
    mult_start = 1'b1;
    tick();
    in_a = 32'd100;
    in_b = 32'd100;
    n = 0;
    dones = 0;
    moved = 1'b0;
    while (mult_done !== 1'b1 && n < 100) begin
      if (out_lo !== 32'h80000001) moved = 1'b1;
      n++;
      tick();
    end
    checks++; if (n >= 100) begin errors++; $display("FAIL held_timeout no done seen"); end
    checks++; if (out_lo !== 32'hF || out_hi !== 32'h0) begin errors++; $display("FAIL held_result got=%h_%h exp=%h_%h", out_hi, out_lo, 32'h0, 32'hF); end
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL held_hilo_stable got=%b exp=0", moved); end
    tick();
    checks++; if (mult_busy !== 1'b0) begin errors++; $display("FAIL held_idle_after_done busy=%b exp=0", mult_busy); end
    mult_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mult_done === 1'b1 || mult_busy === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL held_no_extra_op got=%0d exp=0", dones); end
    checks++; if (out_lo !== 32'hF) begin errors++; $display("FAIL held_lo_retained got=%h exp=%h", out_lo, 32'hF); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] hi, lo;
    int bc, dc, da, act;
    logic st, to;
    in_a = 32'd7;
    in_b = 32'd9;
    mult_start = 1'b1;
    tick();
    mult_start = 1'b0;
    repeat (9) tick();
    checks++; if (mult_busy !== 1'b1) begin errors++; $display("FAIL midrst_running busy=%b exp=1", mult_busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (out_hi !== 32'h0 || out_lo !== 32'h0) begin errors++; $display("FAIL midrst_hilo got=%h_%h exp=0_0", out_hi, out_lo); end
    checks++; if (mult_busy !== 1'b0 || mult_done !== 1'b0) begin errors++; $display("FAIL midrst_flags busy=%b done=%b exp 0 0", mult_busy, mult_done); end
    act = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mult_busy === 1'b1 || mult_done === 1'b1) act++;
    end
    checks++; if (act != 0) begin errors++; $display("FAIL midrst_aborted activity=%0d exp=0", act); end
    do_mult(32'd2, 32'd2, hi, lo, bc, dc, da, st, to);
    checks++; if (lo !== 32'd4 || hi !== 32'd0) begin errors++; $display("FAIL midrst_2x2 got=%h_%h exp=%h_%h", hi, lo, 32'h0, 32'h4); end
    checks++; if (bc != 33 || dc != 1) begin errors++; $display("FAIL midrst_2x2_timing busy=%0d dones=%0d exp 33 1", bc, dc); end
  endtask

  initial begin
    #1;
    test_reset();
    test_small();
    test_signed();
    test_start_held();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
